bit32_1to4demux_reg: RTL and testbench
======================================

// Module: bit32_1to4demux_reg
// PURPOSE
//  Registered 32-bit 1-to-4 demultiplexer with valid/ready handshakes.
//  - Routes each word from one input stream to one of four output channels, chosen per word by in_sel.
//  - Each channel has its own one-entry holding register, so a stalled channel does not block words bound for other channels.
//  - Sits at the far end of the 4:1 mux datapaths: it fans one shared bus back out to four consumers.
// PARAMETERS
//  WIDTH    32   data width of in_data and each out_dataN
//  CNT_W    16   width of per-channel transfer counters (DEMUX_CNT_EN only)
// PORTS
//  clk        in   1      sole clock; all state updates on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_data    in   WIDTH  input word
//  in_sel     in   2      destination channel for in_data (0..3)
//  in_valid   in   1      in_data/in_sel valid
//  in_ready   out  1      block accepts the word this cycle
//  out_data0..3  out WIDTH  per-channel held word
//  out_valid  out  4      bit N: out_dataN holds a word
//  out_ready  in   4      bit N: consumer N accepts out_dataN this cycle
//  cnt_clr    in   1      synchronous clear of all transfer counters
//  cnt0..3    out  CNT_W  per-channel completed-transfer count
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - out_valid=4'b0000, out_data0..3=0, cnt0..3=0.
//    - in_ready reads 1 only once rst is released.
//  - Handshake terms:
//    - Input accept: in_valid & in_ready.
//    - Output N transfer: out_valid[N] & out_ready[N].
//    - Producer holds in_data/in_sel stable while in_valid=1 & in_ready=0.
//  - in_ready (combinational) = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
//    - Depends only on the selected channel; the other channels' state is irrelevant.
//  - Latency: a word accepted in cycle T appears on out_data[in_sel] with out_valid set in cycle T+1.
//  - Per channel N, next state:
//    - accept to N: out_dataN<=in_data, out_valid[N]<=1. Covers the simultaneous drain+fill case: back-to-back, no bubble.
//    - transfer on N and no accept to N: out_valid[N]<=0; out_dataN holds its old value.
//    - else: hold.
//  - Throughput: 1 word/cycle to any single channel while its consumer keeps out_ready high.
//  - Ordering: words to the same channel leave in acceptance order. No ordering guarantee across channels.
//  - out_dataN and out_valid[N] are stable while out_valid[N]=1 & out_ready[N]=0.
//  - in_valid=0: in_sel and in_data are don't-care; no state changes except output drains.
//  - Reset mid-operation: held words are discarded and out_valid clears immediately (async). No partial transfers complete.
// CONFIGURATION
//  - Macro DEMUX_CNT_EN defined:
//    - cntN increments by 1 on each output-N transfer.
//    - Counters saturate at 2^CNT_W-1 (no wrap).
//    - cnt_clr=1 zeroes all counters, taking priority over an increment in the same cycle.
//  - Macro not defined: no counter logic is built; cnt0..3 are tied to 0 and cnt_clr is ignored.
//    - Port list is identical either way.
// TESTING
//  1. Reset, then out_ready=4'hF and in_sel=2, data 32'hDEADBEEF -> accepted in cycle 0; out_valid=4'b0100 and out_data2=DEADBEEF in cycle 1; cleared in cycle 2.
//  2. out_ready[1]=0, send A to ch1 then B to ch1 -> A accepted, B sees in_ready=0.
//     Raise out_ready[1] -> A transfers and B is accepted in the same cycle; B is on out_data1 next cycle.
//  3. Ch0 stalled and full; send to ch3 -> in_ready=1, ch3 gets the word, out_data0 is unchanged.
//  4. Stream 8 words to ch0 with out_ready[0]=1 every cycle -> 8 consecutive accepts, no bubbles, order preserved.
//  5. Assert rst while out_valid=4'b1011 -> out_valid=0 asynchronously, before the next clk edge. After release, the first accepted word emerges normally.
//  6. With DEMUX_CNT_EN and CNT_W=4: 20 transfers on ch2 -> cnt2=15 (saturated).
//     Then cnt_clr=1 in the same cycle as a transfer -> cnt2=0.
//     Built without the macro -> all cnt outputs are 0.

Source files
------------

// File: rtl/bit32_1to4demux_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry holding register per channel.
// Optional per-channel saturating transfer counters are built when DEMUX_CNT_EN is defined.
module bit32_1to4demux_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   logic [WIDTH-1:0] data_arr [4];
   logic [CNT_W-1:0] cnt_arr  [4];
   logic             in_accept;

   // Only the addressed channel gates acceptance, so a stalled channel never blocks the others.
   assign in_ready  = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
   assign in_accept = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic             accept_n;
         logic             xfer_n;
         logic             valid_q;
         logic             valid_d;
         logic [WIDTH-1:0] data_q;
         logic [WIDTH-1:0] data_d;

         assign accept_n = in_accept & (in_sel == 2'(gi));
         assign xfer_n   = valid_q & out_ready[gi];

         // A fill wins over a drain, which gives back-to-back transfers with no bubble.
         always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (accept_n) begin
               valid_d = 1'b1;
               data_d  = in_data;
            end else if (xfer_n) begin
               valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
            end
         end

         assign out_valid[gi] = valid_q;
         assign data_arr[gi]  = data_q;

`ifdef DEMUX_CNT_EN
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Clear beats increment; the count sticks at all-ones instead of wrapping.
         always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
               cnt_d = '0;
            end else if (xfer_n && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_arr[gi] = cnt_q;
`else
         assign cnt_arr[gi] = '0;
`endif
      end
   endgenerate

`ifndef DEMUX_CNT_EN
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
`endif

   assign out_data0 = data_arr[0];
   assign out_data1 = data_arr[1];
   assign out_data2 = data_arr[2];
   assign out_data3 = data_arr[3];

   assign cnt0 = cnt_arr[0];
   assign cnt1 = cnt_arr[1];
   assign cnt2 = cnt_arr[2];
   assign cnt3 = cnt_arr[3];

endmodule

// File: tb/tb_bit32_1to4demux_reg.sv
// Directed bench for bit32_1to4demux_reg; counter expectations follow DEMUX_CNT_EN.
module tb_bit32_1to4demux_reg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bit32_1to4demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt_clr   (cnt_clr),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_sel = 2'd0; in_valid = 1'b0; out_ready = 4'h0; cnt_clr = 1'b0;
      tick();
      drive(1'b1, 2'd0, 32'h1234_5678, 4'hF);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_out_data2", out_data2, 32'd0);
      chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
      tick();
      chk("rst_held_valid", {28'd0, out_valid}, 32'd0);
      rst = 1'b0;
      drive(1'b0, 2'd0, 32'd0, 4'hF);

      // single word to ch2, one-cycle latency, then drained
      drive(1'b1, 2'd2, 32'hDEAD_BEEF, 4'hF);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      chk("t1_valid", {28'd0, out_valid}, 32'h4);
      chk("t1_data2", out_data2, 32'hDEAD_BEEF);
      tick();
      chk("t1_drained", {28'd0, out_valid}, 32'h0);
      chk("t1_data2_hold", out_data2, 32'hDEAD_BEEF);

      // stalled ch1: B waits, then drain+fill in one cycle
      drive(1'b1, 2'd1, 32'hAAAA_0001, 4'b1101);
      chk("t2_a_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b1, 2'd1, 32'hBBBB_0002, 4'b1101);
      chk("t2_b_blocked", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t2_a_held", out_data1, 32'hAAAA_0001);
      chk("t2_a_valid", {28'd0, out_valid}, 32'h2);
      drive(1'b1, 2'd1, 32'hBBBB_0002, 4'hF);
      chk("t2_b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      chk("t2_b_data", out_data1, 32'hBBBB_0002);
      chk("t2_b_valid", {28'd0, out_valid}, 32'h2);
      tick();
      chk("t2_drained", {28'd0, out_valid}, 32'h0);

      // ch0 stalled and full does not block ch3
      drive(1'b1, 2'd0, 32'hC0C0_C0C0, 4'b1110);
      tick();
      drive(1'b1, 2'd0, 32'h0BAD_0BAD, 4'b1110);
      chk("t3_ch0_blocked", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 2'd3, 32'hD3D3_D3D3, 4'b1110);
      chk("t3_ch3_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'b1110);
      chk("t3_valid", {28'd0, out_valid}, 32'h9);
      chk("t3_data3", out_data3, 32'hD3D3_D3D3);
      chk("t3_data0", out_data0, 32'hC0C0_C0C0);
      tick();
      chk("t3_ch3_drain", {28'd0, out_valid}, 32'h1);
      chk("t3_data0_keep", out_data0, 32'hC0C0_C0C0);
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      tick();
      chk("t3_ch0_drain", {28'd0, out_valid}, 32'h0);

      // 8-word stream to ch0, one per cycle
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd0, 32'h0000_1000 + i, 4'hF);
         chk($sformatf("t4_ready%0d", i), {31'd0, in_ready}, 32'd1);
         tick();
         chk($sformatf("t4_data%0d", i), out_data0, 32'h0000_1000 + i);
         chk($sformatf("t4_valid%0d", i), {28'd0, out_valid}, 32'h1);
      end
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      tick();
      chk("t4_drained", {28'd0, out_valid}, 32'h0);

      // build 1011, then async reset between edges
      drive(1'b1, 2'd0, 32'h0000_00A0, 4'h0);
      tick();
      drive(1'b1, 2'd1, 32'h0000_00A1, 4'h0);
      tick();
      drive(1'b1, 2'd3, 32'h0000_00A3, 4'h0);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'h0);
      chk("t5_pre_valid", {28'd0, out_valid}, 32'hB);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_valid", {28'd0, out_valid}, 32'h0);
      chk("t5_async_data0", out_data0, 32'd0);
      chk("t5_async_ready", {31'd0, in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b1, 2'd1, 32'h55AA_55AA, 4'hF);
      chk("t5_post_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      chk("t5_post_valid", {28'd0, out_valid}, 32'h2);
      chk("t5_post_data1", out_data1, 32'h55AA_55AA);
      tick();

      // 20 transfers on ch2 saturate a 4-bit counter; clear beats a same-cycle transfer
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'd2, 32'h0000_2000 + i, 4'hF);
         tick();
      end
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      tick();
`ifdef DEMUX_CNT_EN
      chk("t6_cnt2_sat", {28'd0, cnt2}, 32'd15);
      chk("t6_cnt1", {28'd0, cnt1}, 32'd1);
`else
      chk("t6_cnt2_off", {28'd0, cnt2}, 32'd0);
      chk("t6_cnt1_off", {28'd0, cnt1}, 32'd0);
`endif
      chk("t6_cnt0", {28'd0, cnt0}, 32'd0);
      chk("t6_cnt3", {28'd0, cnt3}, 32'd0);
      drive(1'b1, 2'd2, 32'h0000_2FFF, 4'hF);
      tick();
      cnt_clr = 1'b1;
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      chk("t6_pre_clr_valid", {28'd0, out_valid}, 32'h4);
      tick();
      cnt_clr = 1'b0;
      chk("t6_cnt2_clr", {28'd0, cnt2}, 32'd0);
      chk("t6_cnt1_clr", {28'd0, cnt1}, 32'd0);
      drive(1'b1, 2'd2, 32'h0000_3000, 4'hF);
      tick();
      drive(1'b0, 2'd0, 32'd0, 4'hF);
      tick();
`ifdef DEMUX_CNT_EN
      chk("t6_cnt2_after", {28'd0, cnt2}, 32'd1);
`else
      chk("t6_cnt2_after_off", {28'd0, cnt2}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
